dmem_store_buffer: RTL

- Sits directly downstream of the single-cycle MIPS core, between the core's data-memory port and the shared memory bus.
- Queues stores in a FIFO so the core does not wait on slow memory writes.
- Serves loads over the bus and asserts stall to freeze the core while a load is outstanding or the FIFO is full.
- Decodes the core's 2-bit store-size code into byte enables and lane-aligned write data.

---
 rtl/dmem_store_buffer_pkg.sv | 64 ++++++
 rtl/dmem_store_buffer_if.sv | 27 ++
 rtl/dmem_store_buffer_fifo.sv | 62 ++++++
 rtl/dmem_store_buffer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer.
//   mw_t        : core store-size code (none / word / half / byte)
//   state_t     : bus sequencer states
//   sb_entry_t  : one queued store {word address, byte enables, lane data}
//   sb_lanes_t  : byte enables + lane-replicated data for one store
//   sb_encode() : little-endian store-size decode into sb_lanes_t
package mips_mem_pkg;

    localparam int SB_AW = 32;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_WORD = 2'b01,
        MW_HALF = 2'b10,
        MW_BYTE = 2'b11
    } mw_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [3:0]       be;
        logic [31:0]      wdata;
    } sb_entry_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } sb_lanes_t;

    // Data is replicated across every lane it could land in; the byte
    // enables alone select which lanes memory actually writes.
    function automatic sb_lanes_t sb_encode(input mw_t         size,
                                            input logic [1:0]  byte_off,
                                            input logic [31:0] data);
        sb_lanes_t r;
        r.be    = 4'b0000;
        r.wdata = 32'h0;
        unique case (size)
            MW_WORD: begin
                r.be    = 4'b1111;
                r.wdata = data;
            end
            MW_HALF: begin
                r.be    = byte_off[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{data[15:0]}};
            end
            MW_BYTE: begin
                r.be    = 4'b0001 << byte_off;
                r.wdata = {4{data[7:0]}};
            end
            default: begin
                r.be    = 4'b0000;
                r.wdata = 32'h0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Memory-bus interface between the store buffer (master) and the shared
// memory (slave).
//   mem_req   : request valid          mem_we    : 1 write, 0 read
//   mem_be    : byte enables           mem_addr  : word-aligned address
//   mem_wdata : lane-aligned wdata     mem_ready : accept / read data valid
//   mem_rdata : read data
interface dmem_store_buffer_if #(
    parameter int AW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_store_buffer_fifo.sv
// sb_fifo: DEPTH-entry synchronous FIFO of sb_entry_t.
//   push/wr_data : enqueue (ignored when full)
//   pop/rd_data  : dequeue; rd_data always shows the head entry
//   full/empty/count : occupancy, count in 0..DEPTH
module sb_fifo
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  sb_entry_t       wr_data,
    input  logic            pop,
    output sb_entry_t       rd_data,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    sb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: entry storage has no reset; the pointers and count alone decide
    // which entries are valid, so resetting the array would only add logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: store FIFO and load sequencer between a single-cycle
// MIPS core and the shared memory bus.
//   clk, reset         : core clock, synchronous active-high reset
//   memwrite           : store size (00 none, 01 word, 10 half, 11 byte)
//   memread            : core executing a load
//   aluout             : byte address from core
//   writedata          : right-justified store data
//   readdata           : full-word load result for the core
//   stall              : freeze PC / register write while high
//   bus (master)       : memory-bus request/response
module dmem_store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           memwrite,
    input  logic                 memread,
    input  logic [AW-1:0]        aluout,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 stall,
    dmem_store_buffer_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        next_state;
    logic          load_done;
    logic          load_wait;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    sb_entry_t     wr_entry;
    sb_entry_t     head;
    sb_lanes_t     lanes;
    logic          issue_write;
    logic          issue_read;
    logic          read_complete;
    logic          store_req;

    assign store_req = (mw_t'(memwrite) != MW_NONE);
    assign load_wait = memread && !load_done;

    // full reflects occupancy at the start of the cycle, so a drain in the
    // same cycle never makes room for that cycle's store.
    assign stall = !reset && (load_wait || (store_req && full));
    assign push  = !reset && store_req && !full && !load_wait;

    assign lanes          = sb_encode(mw_t'(memwrite), aluout[1:0], writedata);
    assign wr_entry.addr  = SB_AW'({aluout[AW-1:2], 2'b00});
    assign wr_entry.be    = lanes.be;
    assign wr_entry.wdata = lanes.wdata;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // IDLE issues the request in the same cycle it decides to, so a store
    // reaches the bus the cycle after it is enqueued. Drains win over reads,
    // which keeps loads ordered behind every older store.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state    = state;
        issue_write   = 1'b0;
        issue_read    = 1'b0;
        pop           = 1'b0;
        read_complete = 1'b0;

        unique case (state)
            IDLE: begin
                if (!empty)         issue_write = 1'b1;
                else if (load_wait) issue_read  = 1'b1;
            end
            WRITE:   issue_write = 1'b1;
            READ:    issue_read  = 1'b1;
            default: next_state  = IDLE;
        endcase

        if (issue_write) begin
            if (bus.mem_ready) begin
                pop        = 1'b1;
                next_state = (count > CW'(1)) ? WRITE : IDLE;
            end else begin
                next_state = WRITE;
            end
        end else if (issue_read) begin
            if (bus.mem_ready) begin
                read_complete = 1'b1;
                next_state    = IDLE;
            end else begin
                next_state = READ;
            end
        end

        // Reset abandons any in-flight request immediately.
        if (reset) begin
            issue_write   = 1'b0;
            issue_read    = 1'b0;
            pop           = 1'b0;
            read_complete = 1'b0;
        end
    end

    always_comb begin
        bus.mem_req   = issue_write || issue_read;
        bus.mem_we    = issue_write;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        if (issue_write) begin
            bus.mem_be    = head.be;
            bus.mem_addr  = AW'(head.addr);
            bus.mem_wdata = head.wdata;
        end else if (issue_read) begin
            bus.mem_be   = 4'b1111;
            bus.mem_addr = {aluout[AW-1:2], 2'b00};
        end
    end

    // load_done is a one-cycle pulse that lets the core commit readdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            load_done <= 1'b0;
            readdata  <= 32'h0;
        end else begin
            state     <= next_state;
            load_done <= read_complete;
            if (read_complete) readdata <= bus.mem_rdata;
        end
    end

endmodule
